// File: rtl/ras_pkg.sv
// Shared constants and FSM encoding for the return-address-stack controller.
package ras_pkg;

  localparam int          RAS_NUM     = 8;
  localparam logic [31:0] LINK_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CORR  = 2'd1,
    FLUSH = 2'd2
  } ras_state_t;

endpackage

// File: rtl/ras_ctrl.sv
// RAS sequencing controller: fetch-side push/pop strobes, registered EX corrections,
// and the two-step correct-then-flush repair sequence after a mispredict.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int PEND_MAX = 15,
  parameter int PEND_W   = $clog2(PEND_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [31:0]       if_pc_i,
  input  logic              if_is_call_i,
  input  logic              if_is_ret_i,
  output logic              if_ready_o,
  output logic              ras_push_o,
  output logic              ras_pop_o,
  output logic [31:0]       ras_push_addr_o,
  input  logic              ex_valid_i,
  input  logic [31:0]       ex_pc_i,
  input  logic              ex_is_link_i,
  input  logic              ex_is_ret_i,
  input  logic              ex_mispredict_i,
  output logic [31:0]       corr_addr_o,
  output logic              corr_link_flag_o,
  output logic              corr_return_flag_o,
  output logic              flush_o,
  output logic [PEND_W-1:0] pend_cnt_o,
  output logic              busy_o
);

  ras_state_t state;
  logic       mis_event;
  logic       fire;
  logic       inc;
  logic       dec;

  assign mis_event  = ex_valid_i & ex_mispredict_i;
  assign if_ready_o = (state == RUN) & ~mis_event & (pend_cnt_o < PEND_W'(PEND_MAX));

  // Strobes are held low while reset is asserted so the RAS never sees a push during reset.
  assign fire            = if_valid_i & if_ready_o & rst;
  assign ras_push_o      = fire & if_is_call_i;
  assign ras_pop_o       = fire & if_is_ret_i;
  assign ras_push_addr_o = if_pc_i + LINK_OFFSET;
  assign busy_o          = (state != RUN);

  assign inc = fire & (if_is_call_i | if_is_ret_i);
  assign dec = ex_valid_i & (ex_is_link_i | ex_is_ret_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= RUN;
      pend_cnt_o         <= '0;
      corr_addr_o        <= '0;
      corr_link_flag_o   <= 1'b0;
      corr_return_flag_o <= 1'b0;
      flush_o            <= 1'b0;
    end else begin
      corr_link_flag_o   <= 1'b0;
      corr_return_flag_o <= 1'b0;
      flush_o            <= 1'b0;
      case (state)
        RUN: begin
          corr_link_flag_o   <= ex_valid_i & ex_is_link_i;
          corr_return_flag_o <= ex_valid_i & ex_is_ret_i;
          if (ex_valid_i)
            corr_addr_o <= ex_pc_i;
          // A mispredict squashes every younger speculative op, so the counter restarts.
          if (mis_event) begin
            state      <= CORR;
            pend_cnt_o <= '0;
          end else if (inc && !dec) begin
            pend_cnt_o <= pend_cnt_o + 1'b1;
          end else if (dec && !inc && pend_cnt_o != '0) begin
            pend_cnt_o <= pend_cnt_o - 1'b1;
          end
        end
        CORR: begin
          state   <= FLUSH;
          flush_o <= 1'b1;
        end
        FLUSH: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl with hand-computed expectations.
module tb_ras_ctrl;

  logic        clk;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic        if_is_call_i;
  logic        if_is_ret_i;
  logic        if_ready_o;
  logic        ras_push_o;
  logic        ras_pop_o;
  logic [31:0] ras_push_addr_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_is_link_i;
  logic        ex_is_ret_i;
  logic        ex_mispredict_i;
  logic [31:0] corr_addr_o;
  logic        corr_link_flag_o;
  logic        corr_return_flag_o;
  logic        flush_o;
  logic [3:0]  pend_cnt_o;
  logic        busy_o;

  int errors;
  int checks;

  ras_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .if_valid_i         (if_valid_i),
    .if_pc_i            (if_pc_i),
    .if_is_call_i       (if_is_call_i),
    .if_is_ret_i        (if_is_ret_i),
    .if_ready_o         (if_ready_o),
    .ras_push_o         (ras_push_o),
    .ras_pop_o          (ras_pop_o),
    .ras_push_addr_o    (ras_push_addr_o),
    .ex_valid_i         (ex_valid_i),
    .ex_pc_i            (ex_pc_i),
    .ex_is_link_i       (ex_is_link_i),
    .ex_is_ret_i        (ex_is_ret_i),
    .ex_mispredict_i    (ex_mispredict_i),
    .corr_addr_o        (corr_addr_o),
    .corr_link_flag_o   (corr_link_flag_o),
    .corr_return_flag_o (corr_return_flag_o),
    .flush_o            (flush_o),
    .pend_cnt_o         (pend_cnt_o),
    .busy_o             (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives fetch and EX inputs, then lets combinational outputs settle.
  task automatic applyStimulus(input logic iv, input logic [31:0] ipc, input logic icall, input logic iret,
                               input logic ev, input logic [31:0] epc, input logic elink, input logic eret,
                               input logic emis);
    if_valid_i      = iv;
    if_pc_i         = ipc;
    if_is_call_i    = icall;
    if_is_ret_i     = iret;
    ex_valid_i      = ev;
    ex_pc_i         = epc;
    ex_is_link_i    = elink;
    ex_is_ret_i     = eret;
    ex_mispredict_i = emis;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle();

    // Reset with a call held on the fetch port.
    applyStimulus(1, 32'hBFC0_0010, 1, 0, 0, 32'h0, 0, 0, 0);
    tick();
    checkOutput("rst_ready", 32'(if_ready_o), 32'd1);
    checkOutput("rst_push", 32'(ras_push_o), 32'd0);
    checkOutput("rst_pend", 32'(pend_cnt_o), 32'd0);
    checkOutput("rst_flush", 32'(flush_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_corr_addr", corr_addr_o, 32'h0);
    tick();
    checkOutput("rst_pend_hold", 32'(pend_cnt_o), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rel_push", 32'(ras_push_o), 32'd1);
    checkOutput("rel_push_addr", ras_push_addr_o, 32'hBFC0_0018);
    tick();
    checkOutput("rel_pend", 32'(pend_cnt_o), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'hBFC0_0010, 1, 0, 0);
    tick();
    checkOutput("rel_corr_link", 32'(corr_link_flag_o), 32'd1);
    checkOutput("rel_pend_drain", 32'(pend_cnt_o), 32'd0);
    idle();

    // Call then return, both resolved correctly.
    applyStimulus(1, 32'h0000_1000, 1, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("call_push", 32'(ras_push_o), 32'd1);
    checkOutput("call_addr", ras_push_addr_o, 32'h0000_1008);
    tick();
    checkOutput("call_pend", 32'(pend_cnt_o), 32'd1);
    applyStimulus(1, 32'h0000_2000, 0, 1, 0, 32'h0, 0, 0, 0);
    checkOutput("ret_pop", 32'(ras_pop_o), 32'd1);
    checkOutput("ret_nopush", 32'(ras_push_o), 32'd0);
    tick();
    checkOutput("ret_pend", 32'(pend_cnt_o), 32'd2);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_1000, 1, 0, 0);
    tick();
    checkOutput("ex1_link", 32'(corr_link_flag_o), 32'd1);
    checkOutput("ex1_ret", 32'(corr_return_flag_o), 32'd0);
    checkOutput("ex1_addr", corr_addr_o, 32'h0000_1000);
    checkOutput("ex1_pend", 32'(pend_cnt_o), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_2000, 0, 1, 0);
    tick();
    checkOutput("ex2_ret", 32'(corr_return_flag_o), 32'd1);
    checkOutput("ex2_link", 32'(corr_link_flag_o), 32'd0);
    checkOutput("ex2_addr", corr_addr_o, 32'h0000_2000);
    checkOutput("ex2_pend", 32'(pend_cnt_o), 32'd0);
    checkOutput("ex2_flush", 32'(flush_o), 32'd0);
    idle();
    tick();
    checkOutput("idle_ret", 32'(corr_return_flag_o), 32'd0);
    checkOutput("idle_addr_hold", corr_addr_o, 32'h0000_2000);

    // Mispredicted jr $31 with a call presented on fetch the same cycle.
    applyStimulus(1, 32'h0000_4000, 1, 0, 1, 32'h0000_3000, 0, 1, 1);
    checkOutput("mis_ready", 32'(if_ready_o), 32'd0);
    checkOutput("mis_push", 32'(ras_push_o), 32'd0);
    tick();
    checkOutput("corr_busy", 32'(busy_o), 32'd1);
    checkOutput("corr_ret", 32'(corr_return_flag_o), 32'd1);
    checkOutput("corr_addr", corr_addr_o, 32'h0000_3000);
    checkOutput("corr_flush", 32'(flush_o), 32'd0);
    checkOutput("corr_pend", 32'(pend_cnt_o), 32'd0);
    checkOutput("corr_push", 32'(ras_push_o), 32'd0);
    idle();
    tick();
    checkOutput("flush_flush", 32'(flush_o), 32'd1);
    checkOutput("flush_busy", 32'(busy_o), 32'd1);
    checkOutput("flush_ret", 32'(corr_return_flag_o), 32'd0);
    checkOutput("flush_ready", 32'(if_ready_o), 32'd0);
    tick();
    checkOutput("post_flush", 32'(flush_o), 32'd0);
    checkOutput("post_busy", 32'(busy_o), 32'd0);
    checkOutput("post_ready", 32'(if_ready_o), 32'd1);
    checkOutput("post_pend", 32'(pend_cnt_o), 32'd0);

    // Fill the in-flight counter to its limit.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 32'h0000_5000 + 32'(i * 4), 1, 0, 0, 32'h0, 0, 0, 0);
      tick();
    end
    applyStimulus(1, 32'h0000_5100, 1, 0, 0, 32'h0, 0, 0, 0);
    checkOutput("full_pend", 32'(pend_cnt_o), 32'd15);
    checkOutput("full_ready", 32'(if_ready_o), 32'd0);
    checkOutput("full_push", 32'(ras_push_o), 32'd0);
    tick();
    checkOutput("full_pend_hold", 32'(pend_cnt_o), 32'd15);
    applyStimulus(1, 32'h0000_5100, 1, 0, 1, 32'h0000_5000, 1, 0, 0);
    tick();
    idle();
    checkOutput("drain1_pend", 32'(pend_cnt_o), 32'd14);
    checkOutput("drain1_ready", 32'(if_ready_o), 32'd1);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_5004 + 32'(i * 4), 1, 0, 0);
      tick();
    end
    idle();
    checkOutput("drain_all_pend", 32'(pend_cnt_o), 32'd0);

    // Simultaneous fetch call and EX link leaves the counter unchanged.
    applyStimulus(1, 32'h0000_9000, 1, 0, 0, 32'h0, 0, 0, 0);
    tick();
    applyStimulus(1, 32'h0000_9100, 1, 0, 1, 32'h0000_9000, 1, 0, 0);
    checkOutput("both_push", 32'(ras_push_o), 32'd1);
    tick();
    checkOutput("both_pend", 32'(pend_cnt_o), 32'd1);
    checkOutput("both_link", 32'(corr_link_flag_o), 32'd1);
    checkOutput("both_addr", corr_addr_o, 32'h0000_9000);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_9100, 1, 0, 0);
    tick();
    idle();
    checkOutput("both_drain", 32'(pend_cnt_o), 32'd0);

    // Mispredict on a plain branch, with EX links arriving during the repair.
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_6000, 0, 0, 1);
    tick();
    checkOutput("plain_corr_link", 32'(corr_link_flag_o), 32'd0);
    checkOutput("plain_corr_ret", 32'(corr_return_flag_o), 32'd0);
    checkOutput("plain_busy", 32'(busy_o), 32'd1);
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_7000, 1, 0, 0);
    tick();
    checkOutput("ign_flush", 32'(flush_o), 32'd1);
    checkOutput("ign_link_corr", 32'(corr_link_flag_o), 32'd0);
    checkOutput("ign_addr", corr_addr_o, 32'h0000_6000);
    tick();
    checkOutput("ign_link_flush", 32'(corr_link_flag_o), 32'd0);
    checkOutput("ign_pend", 32'(pend_cnt_o), 32'd0);
    checkOutput("ign_end_flush", 32'(flush_o), 32'd0);
    idle();

    // Reset asserted while in CORR.
    applyStimulus(0, 32'h0, 0, 0, 1, 32'h0000_8000, 1, 0, 1);
    tick();
    idle();
    checkOutput("rc_busy_pre", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rc_busy", 32'(busy_o), 32'd0);
    checkOutput("rc_link", 32'(corr_link_flag_o), 32'd0);
    checkOutput("rc_addr", corr_addr_o, 32'h0);
    checkOutput("rc_ready", 32'(if_ready_o), 32'd1);
    tick();
    checkOutput("rc_flush1", 32'(flush_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rc_flush2", 32'(flush_o), 32'd0);
    checkOutput("rc_busy_post", 32'(busy_o), 32'd0);
    checkOutput("rc_pend", 32'(pend_cnt_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Sequencing controller for the return-address stack in the IF branch-prediction path.
- Turns predecoded call/return events from fetch into RAS push/pop strobes with the link address (PC+8, MIPS delay slot).
- Forwards in-order EX resolutions as correction strobes.
- On a mispredict, schedules the two-step repair the RAS needs: correction registered first, flush one cycle later. Fetch-side updates are blocked while the repair runs.

Parameters:
- RAS_NUM, 8, RAS depth; must be a power of two.
- PEND_MAX, 15, maximum number of speculative call/return ops in flight.
- PEND_W, $clog2(PEND_MAX+1), width of the in-flight counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- if_valid_i  in  1  fetch slot valid.
- if_pc_i  in  32  PC of the fetched instruction.
- if_is_call_i  in  1  predecode: jal/jalr/bal writing $31.
- if_is_ret_i  in  1  predecode: jr $31.
- if_ready_o  out  1  fetch may advance; low during repair or when pending is full.
- ras_push_o  out  1  push strobe to RAS.
- ras_pop_o  out  1  pop strobe to RAS.
- ras_push_addr_o  out  32  link address, if_pc_i+8.
- ex_valid_i  in  1  EX resolves one control-flow instruction, in program order.
- ex_pc_i  in  32  PC of the resolved instruction.
- ex_is_link_i  in  1  resolved instruction writes $31.
- ex_is_ret_i  in  1  resolved instruction is jr $31.
- ex_mispredict_i  in  1  resolved target differs from the predicted target.
- corr_addr_o  out  32  correction PC (the RAS adds 8 itself).
- corr_link_flag_o  out  1  correction push.
- corr_return_flag_o  out  1  correction pop.
- flush_o  out  1  RAS flush: copy the committed stack into the speculative stack.
- pend_cnt_o  out  PEND_W  speculative ops in flight.
- busy_o  out  1  repair in progress.

Behaviour:
- Reset (rst=0, async): state=RUN. All outputs 0 except if_ready_o=1. pend_cnt=0.
- Fetch fire = if_valid_i & if_ready_o.
  - ras_push_o = fire & if_is_call_i.
  - ras_pop_o = fire & if_is_ret_i. Both may be 1 together (jalr $31,$31); the RAS treats that as a replace.
  - These three outputs are combinational, zero latency. The RAS registers them internally.
- ras_push_addr_o = if_pc_i + 32'd8, modulo 2^32, always driven.
- Correction outputs are registered, one cycle after the EX event:
  - corr_link_flag_o <= ex_valid_i & ex_is_link_i.
  - corr_return_flag_o <= ex_valid_i & ex_is_ret_i.
  - corr_addr_o <= ex_pc_i, captured only when ex_valid_i; otherwise held.
- FSM states:
  - RUN: if ex_valid_i & ex_mispredict_i, go to CORR.
  - CORR (1 cycle): the correction for the mispredicted instruction is on corr_*; flush_o=0. Go to FLUSH.
  - FLUSH (1 cycle): flush_o=1. Go to RUN.
- busy_o = (state != RUN).
- if_ready_o = (state == RUN) & ~ex_mispredict_event & (pend_cnt < PEND_MAX).
  - ex_mispredict_event = ex_valid_i & ex_mispredict_i.
  - Consequence: no push/pop is issued in the mispredict cycle, CORR, or FLUSH.
- ex_valid_i in CORR/FLUSH: ignored, no correction generated. The pipeline is being squashed by the same mispredict.
- pend_cnt:
  - +1 on fire & (if_is_call_i | if_is_ret_i).
  - -1 on ex_valid_i & (ex_is_link_i | ex_is_ret_i) in RUN.
  - Simultaneous inc and dec: unchanged.
  - Set to 0 on entry to CORR; the mispredict squashes all younger ops.
  - Never wraps: increments are blocked at PEND_MAX via if_ready_o, and decrements are ignored at 0.
- A mispredict on a non-link, non-return branch still runs CORR/FLUSH. corr flags are 0 in that case, so the RAS simply restores the committed stack.
- Reset asserted mid-repair returns to RUN immediately, with all strobes low.

Decomposition:
- Shared package (ras_pkg / defines):
  - RAS_NUM.
  - Link offset constant 32'd8.
  - FSM state encoding: RUN=2'd0, CORR=2'd1, FLUSH=2'd2.
- No sub-module. The FSM, counter and correction registers live in one block, instantiated beside RAS in IF.

Test Plan:
- Reset with if_valid_i=1, if_is_call_i=1 held, then release -> during reset no push, if_ready_o=1. First cycle after release: ras_push_o=1, ras_push_addr_o=if_pc_i+8 (pc 0xBFC00010 -> 0xBFC00018), pend_cnt_o=1 next cycle.
- Call at 0x1000 then ret at 0x2000. EX resolves both without mispredict -> corr_link_flag_o=1 with corr_addr_o=0x1000 one cycle after the first EX, corr_return_flag_o=1 one cycle after the second. pend_cnt_o returns to 0. flush_o stays 0.
- EX mispredict on jr $31 at 0x3000 -> that cycle if_ready_o=0. Next cycle: CORR, corr_return_flag_o=1, corr_addr_o=0x3000. Cycle after: flush_o=1 for exactly one cycle. Then busy_o=0 and if_ready_o=1. pend_cnt_o=0.
- Issue 15 calls with no EX resolution -> pend_cnt_o=15, if_ready_o=0, no 16th push. Then one EX link -> pend_cnt_o=14 and if_ready_o=1 in the next cycle.
- Same-cycle fetch call and EX link in RUN -> push issued, correction registered, pend_cnt_o unchanged.
- ex_valid_i with ex_is_link_i during CORR or FLUSH -> no corr_link_flag_o; flush still occurs; pend_cnt_o=0.
- rst low during CORR -> flush_o never asserts; outputs at reset values.
